// File: rtl/seq_comparator.sv
// Digit-serial magnitude comparator: evaluates "a op b" one DIGIT-bit slice per cycle,
// MSB slice first, with a fixed latency of N cycles and a valid/ready handshake.
module seq_comparator #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sign_flip;
    logic [2:0]       op_r;
    logic [CW-1:0]    cnt;
    logic             gt;
    logic             lt;
    logic             gt_n;
    logic             lt_n;
    logic             y_n;
    logic [DIGIT-1:0] slice_a;
    logic [DIGIT-1:0] slice_b;
    logic             last;

    // Flipping the MSB maps two's-complement ordering onto unsigned ordering.
    assign sign_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    assign slice_a = a_sh[WIDTH-1 -: DIGIT];
    assign slice_b = b_sh[WIDTH-1 -: DIGIT];
    assign last    = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The first differing slice decides the ordering; later slices are ignored.
    always_comb begin
        gt_n = gt;
        lt_n = lt;
        if (!gt && !lt) begin
            gt_n = (slice_a > slice_b);
            lt_n = (slice_a < slice_b);
        end
    end

    always_comb begin
        y_n = 1'b0;
        case (op_r)
            3'b000:  y_n = !gt_n && !lt_n;
            3'b001:  y_n = gt_n || lt_n;
            3'b010:  y_n = lt_n;
            3'b011:  y_n = !gt_n;
            3'b100:  y_n = gt_n;
            3'b101:  y_n = !lt_n;
            default: y_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            op_r <= '0;
            cnt  <= '0;
            gt   <= 1'b0;
            lt   <= 1'b0;
            y    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= a ^ sign_flip;
                        b_sh <= b ^ sign_flip;
                        op_r <= op;
                        cnt  <= '0;
                        gt   <= 1'b0;
                        lt   <= 1'b0;
                    end
                end
                BUSY: begin
                    gt   <= gt_n;
                    lt   <= lt_n;
                    a_sh <= a_sh << DIGIT;
                    b_sh <= b_sh << DIGIT;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        y <= y_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 8: bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL define derived constant N = WIDTH/DIGIT: number of compare cycles.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a request.
REQ-008 SHALL have port a  input  WIDTH  left operand.
REQ-009 SHALL have port b  input  WIDTH  right operand.
REQ-010 SHALL have port signed_mode  input  1  1 = two's-complement compare; 0 = unsigned compare.
REQ-011 SHALL have port op  input  3  relation: 000 eq, 001 ne, 010 lt, 011 le, 100 gt, 101 ge; 110 and 111 reserved.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port y  output  1  result of the relation "a op b".

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE.
REQ-017 SHALL drive out_valid = 1 only in DONE.
REQ-018 SHALL treat in_valid & in_ready on a rising edge as an accept: latch a, b, signed_mode and op, clear digit counter and flags, and enter BUSY.
REQ-019 SHALL, when signed_mode = 1, invert the MSB of both latched operands so that an unsigned compare yields the signed ordering.
REQ-020 SHALL, in BUSY, compare one DIGIT-bit slice per cycle, MSB slice first, for exactly N cycles.
REQ-021 SHALL keep sticky flags gt and lt, both 0 at accept, and update them only while both are 0: set gt if slice_a > slice_b, set lt if slice_a < slice_b.
REQ-022 SHALL, after the N-th slice, compute y from gt, lt and op and enter DONE. Equality is gt = 0 and lt = 0. Reserved op values give y = 0.
REQ-023 SHALL have fixed latency: for an accept at edge k, out_valid rises after edge k+N and is independent of the data.
REQ-024 SHALL hold y and out_valid stable in DONE until out_valid & out_ready.
REQ-025 SHALL return from DONE to IDLE on the edge where out_ready = 1, so in_ready = 1 in the next cycle. There is no bypass and no overlap of requests.
REQ-026 SHALL ignore in_valid, a, b, op and signed_mode outside IDLE. Changing them during BUSY SHALL NOT affect the result.
REQ-027 SHALL keep y at its last computed value outside DONE. Consumers SHALL qualify y with out_valid.

Reset
REQ-028 SHALL, while rst = 1 at a rising edge, force state = IDLE, out_valid = 0, y = 0, counter = 0, gt = lt = 0, and in_ready = 1 after that edge.
REQ-029 SHALL abort an in-flight operation when rst is asserted in BUSY or DONE. No result SHALL be emitted for the aborted request.
REQ-030 SHALL give rst priority over a simultaneous accept or out_ready.

Verification (WIDTH=32, DIGIT=8, N=4)
REQ-031 Bench SHALL check sign handling: a=0xFFFFFFFF, b=0x00000000, op=le.
- signed_mode=1 -> y=1, with out_valid exactly 4 cycles after the accept.
- signed_mode=0 -> y=0.
REQ-032 Bench SHALL check the extreme values: a=0x7FFFFFFF, b=0x80000000, op=gt.
- signed_mode=1 -> y=1.
- signed_mode=0 -> y=0.
REQ-033 Bench SHALL check equal operands: a=b=0x80000000, signed_mode=1.
- op=eq -> y=1; op=le -> y=1; op=lt -> y=0; op=ne -> y=0; op=110 -> y=0.
REQ-034 Bench SHALL check a difference in the final slice only: a=0x12345678, b=0x12345679, signed_mode=0.
- op=lt -> y=1; op=ge -> y=0.
- Also a=0x12345679, b=0x12345678 (difference in the last slice only), op=gt -> y=1.
REQ-035 Bench SHALL check backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid, a and b.
- out_valid=1, y stable and in_ready=0 throughout.
- After out_ready=1, in_ready=1 on the next cycle.
- A following request (a=1, b=2, unsigned lt) -> y=1.
REQ-036 Bench SHALL check reset mid-operation: assert rst for 1 cycle, 2 cycles after an accept.
- Next cycle: out_valid=0, in_ready=1, y=0.
- No out_valid pulse for the aborted request.
- A new request completes normally 4 cycles after its accept.
